// File: rtl/pc_fetch_queue.sv
// PC owner and fetch front-end: issues one outstanding word fetch at a time,
// queues returned instructions with their PCs, and hands them to IF_ID.
module pc_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr_out,
    output logic [31:0]      instr_pc,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [31:0]        instr_mem_q [DEPTH];
    logic [31:0]        instr_mem_d [DEPTH];
    logic [31:0]        pc_mem_q    [DEPTH];
    logic [31:0]        pc_mem_d    [DEPTH];

    logic               push, pop, fetch_ok;
    logic [CNT_W:0]     cnt_next;

    assign push     = (state_q == S_WAIT) && imem_ack && !redirect_valid;
    assign pop      = (cnt_q != '0) && instr_ready && !redirect_valid;
    assign cnt_next = {1'b0, cnt_q} + (CNT_W + 1)'(push) - (CNT_W + 1)'(pop);
    // Only start a fetch when its response is guaranteed a free slot.
    assign fetch_ok = cnt_next < DEPTH_C;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        head_d      = head_q;
        tail_d      = tail_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (redirect_valid) begin
            cnt_d  = '0;
            head_d = '0;
            tail_d = '0;
            pc_d   = redirect_pc;
            // An unanswered request must still be drained, its data dropped.
            case (state_q)
                S_WAIT, S_DISCARD: state_d = imem_ack ? S_WAIT : S_DISCARD;
                default:           state_d = S_WAIT;
            endcase
        end else begin
            if (push) begin
                instr_mem_d[tail_q] = imem_rdata;
                pc_mem_d[tail_q]    = pc_q;
                tail_d              = tail_q + PTR_W'(1);
                pc_d                = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            cnt_d = cnt_next[CNT_W-1:0];
            case (state_q)
                S_IDLE:            state_d = fetch_ok ? S_WAIT : S_IDLE;
                S_WAIT, S_DISCARD: begin
                    if (imem_ack) state_d = fetch_ok ? S_WAIT : S_IDLE;
                end
                default:           state_d = S_IDLE;
            endcase
        end

        req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (cnt_q != '0);
    assign instr_out   = instr_mem_q[head_q];
    assign instr_pc    = pc_mem_q[head_q];
    assign occupancy   = cnt_q;

endmodule
